eth_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that merges N_PORTS 8-bit byte-stream frame sources onto one 8-bit output stream.
- Each source is typically a frame FIFO, so frames arrive contiguous; the output feeds a single MAC TX path or a downstream frame FIFO.
- A grant is held from the first beat of a frame until its last beat is accepted, so frames never interleave.
- The source port index travels alongside each beat as m_id.

---
 rtl/eth_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 41 ++++
 rtl/eth_frame_arbiter.sv | 117 +++++++++++
 tb/tb_eth_frame_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// ============================================================================
//  Module      : eth_arb_pkg
//  Description : Shared state encoding and counter width for the frame arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package eth_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int FRAME_CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector; first set req bit after ptr.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_PORTS  = 4,
    parameter int ID_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    localparam logic [ID_WIDTH:0] N_EXT = (ID_WIDTH + 1)'(N_PORTS);

    logic [ID_WIDTH:0] w_cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            w_cand = {1'b0, ptr_i} + (ID_WIDTH + 1)'(k);
            if (w_cand >= N_EXT) begin
                w_cand = w_cand - N_EXT;
            end
            if (req_i[w_cand[ID_WIDTH-1:0]]) begin
                found_o = 1'b1;
                idx_o   = w_cand[ID_WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_frame_arbiter.sv
// ============================================================================
//  Module      : eth_frame_arbiter
//  Description : Frame-granular round-robin merge of N byte streams onto one.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module eth_frame_arbiter
    import eth_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_PORTS-1:0]            port_enable,
    input  logic [N_PORTS*8-1:0]          s_data,
    input  logic [N_PORTS-1:0]            s_last,
    input  logic [N_PORTS*USER_WIDTH-1:0] s_user,
    input  logic [N_PORTS-1:0]            s_valid,
    output logic [N_PORTS-1:0]            s_ready,
    output logic [7:0]                    m_data,
    output logic                          m_last,
    output logic [USER_WIDTH-1:0]         m_user,
    output logic [ID_WIDTH-1:0]           m_id,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          grant_active,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [FRAME_CNT_W-1:0]        frame_count
);

    arb_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic                   active_q, active_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic [7:0]             w_data_arr [N_PORTS];
    logic [USER_WIDTH-1:0]  w_user_arr [N_PORTS];
    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_pick;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign w_data_arr[gi] = s_data[8*gi +: 8];
        assign w_user_arr[gi] = s_user[USER_WIDTH*gi +: USER_WIDTH];
    end

    rr_pick #(
        .N_PORTS  (N_PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_i   (s_valid & port_enable),
        .ptr_i   (rr_ptr_q),
        .found_o (w_found),
        .idx_o   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            rr_ptr_q      <= ID_WIDTH'(N_PORTS - 1);
            active_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            active_q      <= active_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Handshakes are gated by reset_n so a frame cut by reset cannot move a beat.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        active_d      = active_q;
        frame_count_d = frame_count_q;
        s_ready       = '0;
        m_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    grant_id_d = w_pick;
                    active_d   = 1'b1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                m_valid             = s_valid[grant_id_q] & reset_n;
                s_ready[grant_id_q] = m_ready & reset_n;
                if (m_valid && m_ready && s_last[grant_id_q]) begin
                    rr_ptr_d      = grant_id_q;
                    frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                    active_d      = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_data       = w_data_arr[grant_id_q];
    assign m_last       = s_last[grant_id_q];
    assign m_user       = w_user_arr[grant_id_q];
    assign m_id         = grant_id_q;
    assign grant_id     = grant_id_q;
    assign grant_active = active_q;
    assign frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_arbiter.sv
// ============================================================================
//  Module      : tb_eth_frame_arbiter
//  Description : Self-checking bench: frame tables, random frames, corner cases.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_eth_frame_arbiter;

    localparam int N  = 4;
    localparam int UW = 1;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    port_enable;
    logic [N*8-1:0]  s_data;
    logic [N-1:0]    s_last;
    logic [N*UW-1:0] s_user;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [7:0]      m_data;
    logic            m_last;
    logic [UW-1:0]   m_user;
    logic [IW-1:0]   m_id;
    logic            m_valid;
    logic            m_ready;
    logic            grant_active;
    logic [IW-1:0]   grant_id;
    logic [31:0]     frame_count;

    always #5 clk = ~clk;

    eth_frame_arbiter #(.N_PORTS(N), .USER_WIDTH(UW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset_n(reset_n), .port_enable(port_enable),
        .s_data(s_data), .s_last(s_last), .s_user(s_user), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_last(m_last), .m_user(m_user),
        .m_id(m_id), .m_valid(m_valid), .m_ready(m_ready),
        .grant_active(grant_active), .grant_id(grant_id), .frame_count(frame_count)
    );

    typedef struct {
        logic [3:0]  en;
        int          nfr;
        int          len;
        int          mr;
        int          n;
        logic [15:0] ord;   // expected port order, 2 bits per frame, first at LSB
        int          fc;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [9:0]  srcq [N][$];       // {user, last, data} per source beat
    logic [11:0] expq [$];          // {id, user, last, data}
    logic [1:0]  exp_order [$];
    logic [1:0]  dut_order [$];
    int          mr_mode;
    bit          use_model;
    int          cyc;
    int          last_acc_cyc;
    bit          in_frame;
    logic [1:0]  cur_id;
    bit          saw_p2;
    logic        smp_mv;
    logic [31:0] smp_fc;
    vec_t        vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        exp_order.delete();
        dut_order.delete();
    endtask

    task automatic load(input int p, input int nfr, input int len);
        logic [9:0] w;
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < len; b++) begin
                w[7:0] = 8'($urandom);
                w[8]   = (b == len - 1);
                w[9]   = 1'($urandom);
                srcq[p].push_back(w);
            end
        end
    endtask

    task automatic drive();
        logic [9:0] h;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                s_valid[i] = 1'b1;
                s_data[8*i +: 8] = h[7:0];
                s_last[i] = h[8];
                s_user[i] = h[9];
            end else begin
                s_valid[i] = 1'b0;
                s_data[8*i +: 8] = 8'h00;
                s_last[i] = 1'b0;
                s_user[i] = 1'b0;
            end
        end
        case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = ~m_ready;
        endcase
    endtask

    function automatic int pending();
        int c = 0;
        for (int i = 0; i < N; i++)
            if (port_enable[i] && srcq[i].size() > 0) c++;
        return c;
    endfunction

    // Reference: serve whole frames round-robin from the queued sources.
    task automatic build_model(input logic [3:0] en, output int nf);
        int rd [N];
        int ptr;
        int p;
        logic [9:0] w;
        for (int i = 0; i < N; i++) rd[i] = 0;
        ptr = N - 1;
        nf  = 0;
        expq.delete();
        exp_order.delete();
        forever begin
            p = -1;
            for (int k = 1; k <= N; k++) begin
                int q = (ptr + k) % N;
                if (p < 0 && en[q] && rd[q] < srcq[q].size()) p = q;
            end
            if (p < 0) break;
            do begin
                w = srcq[p][rd[p]];
                rd[p]++;
                expq.push_back({2'(p), w});
            end while (!w[8]);
            exp_order.push_back(2'(p));
            ptr = p;
            nf++;
        end
    endtask

    task automatic monitor();
        logic [3:0] exp_rdy;
        exp_rdy = (grant_active && reset_n) ? (4'(m_ready) << m_id) : 4'h0;
        chk("s_ready_vs_grant", s_ready, exp_rdy);
        chk("s_ready_disabled", s_ready & ~port_enable, 0);
        if (!grant_active) chk("m_valid_idle", m_valid, 0);
    endtask

    task automatic accept();
        logic [9:0]  beat;
        logic [11:0] e;
        beat = {m_user, m_last, m_data};
        if (use_model) begin
            if (expq.size() == 0) chk("extra_beat", 1, 0);
            else begin
                e = expq.pop_front();
                chk("beat", {m_id, beat}, e);
            end
        end else begin
            if (srcq[m_id].size() == 0) chk("beat_src_empty", 1, 0);
            else chk("beat_src", beat, srcq[m_id][0]);
        end
        if (in_frame) chk("no_interleave", m_id, cur_id);
        cur_id   = m_id;
        in_frame = !m_last;
        if (m_id == 2'd2) saw_p2 = 1'b1;
        if (m_last) begin
            dut_order.push_back(m_id);
            last_acc_cyc = cyc;
        end
    endtask

    task automatic cycle();
        logic [3:0] pop;
        @(negedge clk);
        cyc++;
        pop    = s_valid & s_ready;
        smp_mv = m_valid;
        smp_fc = frame_count;
        monitor();
        if (m_valid && m_ready) accept();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_frame = 1'b0;
        drive();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            if (k == 1) begin
                chk("rst_grant_active", grant_active, 0);
                chk("rst_grant_id", grant_id, 0);
                chk("rst_frame_count", frame_count, 0);
            end
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        cyc = 0;
        drive();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        forever begin
            cycle();
            n++;
            if (!grant_active && pending() == 0) break;
            if (n >= budget) begin
                chk("timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        cv;
        logic [15:0] o;
        int          nfm;
        logic [3:0]  en;

        reset_n = 1'b0; port_enable = '0; s_data = '0; s_last = '0; s_user = '0;
        s_valid = '0; m_ready = 1'b0; mr_mode = 0; use_model = 1'b1;
        cyc = 0; last_acc_cyc = 0; in_frame = 1'b0; cur_id = '0; saw_p2 = 1'b0;

        vt[0] = '{4'b0001, 1, 3, 0, 1, 16'h0000, 1};
        vt[1] = '{4'b1111, 1, 2, 0, 4, 16'h00E4, 4};   // 0,1,2,3
        vt[2] = '{4'b1101, 2, 1, 0, 6, 16'h0E38, 6};   // 0,2,3,0,2,3
        vt[3] = '{4'b0001, 3, 3, 1, 3, 16'h0000, 3};
        vt[4] = '{4'b1010, 1, 4, 2, 2, 16'h000D, 2};   // 1,3
        vt[5] = '{4'b1111, 2, 1, 1, 8, 16'hE4E4, 8};

        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            cv = vt[v];
            clear_q();
            for (int p = 0; p < N; p++) load(p, cv.nfr, cv.len);
            port_enable = cv.en;
            mr_mode     = cv.mr;
            use_model   = 1'b1;
            do_reset();
            build_model(cv.en, nfm);
            run_until_done(600);
            chk("vec_frame_count", frame_count, cv.fc);
            chk("vec_order_len", dut_order.size(), cv.n);
            o = cv.ord;
            for (int k = 0; k < cv.n && k < dut_order.size(); k++)
                chk("vec_order", dut_order[k], o[2*k +: 2]);
            if (cv.mr == 0) chk("vec_cycles", last_acc_cyc, cv.fc * (cv.len + 1));
            chk("vec_drained", expq.size(), 0);
        end

        for (int r = 0; r < 6; r++) begin
            clear_q();
            mr_mode = $urandom_range(0, 2);
            en      = 4'($urandom_range(1, 15));
            for (int p = 0; p < N; p++) begin
                int nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) load(p, 1, $urandom_range(1, 5));
            end
            port_enable = en;
            use_model   = 1'b1;
            do_reset();
            build_model(en, nfm);
            run_until_done(2000);
            chk("rnd_frame_count", frame_count, nfm);
            chk("rnd_order_len", dut_order.size(), exp_order.size());
            for (int k = 0; k < exp_order.size() && k < dut_order.size(); k++)
                chk("rnd_order", dut_order[k], exp_order[k]);
            chk("rnd_drained", expq.size(), 0);
        end

        // Enabling port 1 while port 2 is mid-frame: it is served right after 3.
        clear_q();
        for (int p = 0; p < N; p++) load(p, 1, 3);
        port_enable = 4'b1101;
        mr_mode = 0;
        use_model = 1'b0;
        do_reset();
        saw_p2 = 1'b0;
        for (int n = 0; n < 50 && !saw_p2; n++) cycle();
        chk("en_mid_reached", saw_p2, 1);
        port_enable = 4'b1111;
        run_until_done(200);
        o = 16'h0078;   // 0,2,3,1
        chk("en_order_len", dut_order.size(), 4);
        for (int k = 0; k < 4 && k < dut_order.size(); k++)
            chk("en_order", dut_order[k], o[2*k +: 2]);

        // Back-to-back single-beat frames from port 3 alternate bubble/beat.
        clear_q();
        load(3, 4, 1);
        port_enable = 4'b1111;
        mr_mode = 0;
        use_model = 1'b1;
        do_reset();
        build_model(port_enable, nfm);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("single_m_valid", smp_mv, (k % 2) == 0);
            chk("single_fc", smp_fc, (k - 1) / 2);
        end
        #1;
        chk("single_fc_end", frame_count, 4);

        // Reset during the 2nd byte of a 5-byte frame on port 2.
        clear_q();
        load(2, 1, 5);
        port_enable = 4'b1111;
        mr_mode = 0;
        use_model = 1'b0;
        in_frame = 1'b0;
        drive();
        cycle();
        cycle();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rmid_s_ready", s_ready, 0);
        chk("rmid_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_q();
        load(0, 1, 2);
        load(2, 1, 2);
        in_frame = 1'b0;
        drive();
        @(negedge clk);
        chk("rmid_idle_s_ready", s_ready, 0);
        chk("rmid_idle_m_valid", m_valid, 0);
        chk("rmid_frame_count", frame_count, 0);
        chk("rmid_grant_active", grant_active, 0);
        @(posedge clk);
        #1;
        drive();
        run_until_done(100);
        chk("rmid_order_len", dut_order.size(), 2);
        if (dut_order.size() >= 2) begin
            chk("rmid_first", dut_order[0], 0);
            chk("rmid_second", dut_order[1], 2);
        end
        chk("rmid_fc_end", frame_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
